// File: rtl/xor_rr_scheduler_if.sv
// Request/result bundle for the shared XOR scheduler: N_REQ operand ports in,
// one tagged result port out.
interface xor_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               res_valid;
    logic [W-1:0]       res_data;
    logic [IDW-1:0]     res_id;
    logic               res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/xor_rr_scheduler.sv
// Round-robin arbiter in front of one shared W-bit XOR datapath with a
// single-entry, requester-tagged result register.
module xor_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    xor_rr_scheduler_if.slave   bus,
    output logic [15:0]         op_count
);
    localparam int IDW = $clog2(N_REQ);

    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_data_q,  res_data_d;
    logic [IDW-1:0]   res_id_q,    res_id_d;
    logic [15:0]      op_count_q,  op_count_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;

    logic             slot_free_s;
    logic             found_s;
    logic [IDW-1:0]   gnt_id_s;
    logic [IDW:0]     idx_s;
    logic [N_REQ-1:0] grant_s;

    assign slot_free_s = !res_valid_q || bus.res_ready;

    // Rotating search from ptr; one extra index bit lets the wrap be done by subtraction.
    always_comb begin
        found_s  = 1'b0;
        gnt_id_s = '0;
        idx_s    = '0;
        grant_s  = '0;
        if (!rst && slot_free_s) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx_s = {1'b0, ptr_q} + (IDW+1)'(k);
                if (idx_s >= (IDW+1)'(N_REQ)) begin
                    idx_s = idx_s - (IDW+1)'(N_REQ);
                end else begin
                    idx_s = idx_s;
                end
                if (!found_s && bus.req_valid[idx_s[IDW-1:0]]) begin
                    found_s  = 1'b1;
                    gnt_id_s = idx_s[IDW-1:0];
                end else begin
                    found_s  = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
        if (found_s) begin
            grant_s[gnt_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Result register next state: accept wins over a plain consume.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        op_count_d  = op_count_q;
        ptr_d       = ptr_q;
        if (found_s) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.req_a[gnt_id_s*W +: W] ^ bus.req_b[gnt_id_s*W +: W];
            res_id_d    = gnt_id_s;
            op_count_d  = op_count_q + 16'd1;
            ptr_d       = (gnt_id_s == IDW'(N_REQ-1)) ? '0 : gnt_id_s + IDW'(1'b1);
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            op_count_q  <= 16'd0;
            ptr_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            op_count_q  <= op_count_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign op_count      = op_count_q;
endmodule
